// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, response type and index helper for the instruction memory
package imem_pkg;

    localparam logic [31:0] IMEM_NOP  = 32'h00000013;
    localparam int          IMEM_XLEN = 32;

    typedef struct packed {
        logic [IMEM_XLEN-1:0] instr;
        logic                 fault;
    } imem_rsp_t;

    // Byte address to word index; callers slice the low bits they need.
    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - two-entry synchronous response FIFO, head zeroed while empty
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter type rsp_t = imem_rsp_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output rsp_t head,
    output logic valid
);

    // Extra pointer bit distinguishes full from empty.
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    rsp_t       entries [2];

    // Pointer update; the owner never pushes when full or pops when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
        end
    end

    // Entry storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push && !reset) entries[wr_ptr[0]] <= push_data;
    end

    assign valid = (wr_ptr != rd_ptr);
    assign head  = valid ? entries[rd_ptr[0]] : '0;

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - instruction memory with valid/ready fetch, load port; IMEM_FAULT_CHECK_EN enables fault checks
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int    XLEN      = 32,
    parameter int    DEPTH     = 64,
    parameter int    ADDR_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_instr,
    output logic              rsp_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_data,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            fault;
    } rsp_t;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [1:0]       cnt;
    logic             accept;
    logic             pop;
    logic [63:0]      req_idx_full;
    logic [63:0]      load_idx_full;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;
    logic             req_fault;
    logic             load_ok;
    rsp_t             fill;
    rsp_t             head;

    assign req_idx_full  = word_index(64'(req_addr));
    assign load_idx_full = word_index(64'(load_addr));
    assign req_idx       = req_idx_full[IDX_W-1:0];
    assign load_idx      = load_idx_full[IDX_W-1:0];

`ifdef IMEM_FAULT_CHECK_EN
    assign req_fault = (req_addr[1:0] != 2'b00) || (|req_idx_full[63:IDX_W]);
    assign load_ok   = ~(|load_idx_full[63:IDX_W]);
`else
    // Index wraps modulo DEPTH; the dropped bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_idx_full[63:IDX_W], load_idx_full[63:IDX_W],
                                req_addr[1:0], load_addr[1:0]};
    assign req_fault = 1'b0;
    assign load_ok   = 1'b1;
`endif

    // Load wins the cycle so a read and write of one word never coincide.
    assign req_ready = !reset && (cnt < 2'd2) && !load_en;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Faulting requests return a NOP without touching storage.
    assign fill.instr = req_fault ? XLEN'(IMEM_NOP) : mem[req_idx];
    assign fill.fault = req_fault;

    // Outstanding count: in-flight plus buffered responses, capped at two.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Program load path; storage survives reset.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) mem[load_idx] <= load_data;
    end

    imem_rsp_fifo #(
        .rsp_t (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (fill),
        .pop       (pop),
        .head      (head),
        .valid     (rsp_valid)
    );

    assign rsp_instr = head.instr;
    assign rsp_fault = head.fault;
    assign busy      = (cnt != 2'd0);

endmodule
